// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// shift_add_multiplier: sequential shift-and-add multiplier, unsigned or
// sign-magnitude operands, with early termination. Rev 1.0
// ============================================================================
module shift_add_multiplier #(
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   multiplier,
  input  logic [W-1:0]   multiplicand,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic           neg,
  output logic           zflag,
  output logic [3:0]     sign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic           sign_cap_q, sign_cap_d;
  logic [2*W-1:0] product_q, product_d;
  logic           neg_q, neg_d;

  logic [W-1:0]   w_mplier_mag;
  logic [W-1:0]   w_mcand_mag;
  logic [2*W-1:0] w_acc_next;
  logic [W-1:0]   w_mplier_shift;

  // In sign-magnitude mode the MSB is the sign and is stripped from the magnitude.
  assign w_mplier_mag   = signed_mode ? {1'b0, multiplier[W-2:0]}   : multiplier;
  assign w_mcand_mag    = signed_mode ? {1'b0, multiplicand[W-2:0]} : multiplicand;
  assign w_acc_next     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign w_mplier_shift = mplier_q >> 1;

  always_comb begin
    state_d    = state_q;
    mplier_d   = mplier_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    sign_cap_d = sign_cap_q;
    product_d  = product_q;
    neg_d      = neg_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mplier_d   = w_mplier_mag;
          mcand_d    = {{W{1'b0}}, w_mcand_mag};
          acc_d      = '0;
          sign_cap_d = signed_mode & (multiplier[W-1] ^ multiplicand[W-1]);
          state_d    = RUN;
        end
      end
      RUN: begin
        acc_d    = w_acc_next;
        mplier_d = w_mplier_shift;
        mcand_d  = mcand_q << 1;
        // Stop as soon as no multiplier bits remain; a zero result is never negative.
        if (w_mplier_shift == '0) begin
          state_d   = DONE;
          product_d = w_acc_next;
          neg_d     = sign_cap_q & (w_acc_next != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= IDLE;
      mplier_q   <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      sign_cap_q <= 1'b0;
      product_q  <= '0;
      neg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mplier_q   <= mplier_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      sign_cap_q <= sign_cap_d;
      product_q  <= product_d;
      neg_q      <= neg_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;
  assign neg     = neg_q;
  assign zflag   = (product_q == '0);
  assign sign    = neg_q ? 4'b1010 : 4'b1100;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// tb_shift_add_multiplier: directed and randomized checks of
// shift_add_multiplier against an arithmetic reference model. Rev 1.0
// ============================================================================
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clock = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   multiplier = '0;
  logic [W-1:0]   multiplicand = '0;
  logic           busy, done, neg, zflag;
  logic [2*W-1:0] product;
  logic [3:0]     sign;

  int tests = 0;
  int fails = 0;
  longint prev_p = 0;
  logic   prev_neg = 1'b0;

  shift_add_multiplier #(.W(W)) dut (
    .clock(clock), .rst(rst), .start(start), .signed_mode(signed_mode),
    .multiplier(multiplier), .multiplicand(multiplicand),
    .busy(busy), .done(done), .product(product), .neg(neg),
    .zflag(zflag), .sign(sign)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    signed_mode  = 1'($urandom);
    multiplier   = W'($urandom);
    multiplicand = W'($urandom);
  endtask

  task automatic run_op(input logic mode, input logic [W-1:0] mr, input logic [W-1:0] md);
    longint a, b, exp_p;
    logic   exp_neg;
    int     exp_len, cycles;
    longint mask;
    mask    = (longint'(1) << (W - 1)) - 1;
    a       = mode ? (longint'(mr) & mask) : longint'(mr);
    b       = mode ? (longint'(md) & mask) : longint'(md);
    exp_p   = a * b;
    exp_neg = mode & (mr[W-1] ^ md[W-1]) & (exp_p != 0);
    exp_len = 1;
    for (int i = 0; i < W; i++) if (a[i]) exp_len = i + 1;

    @(negedge clock);
    start = 1'b1; signed_mode = mode; multiplier = mr; multiplicand = md;
    @(negedge clock);
    start = 1'b0;
    scramble_inputs();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_done_low", 64'(done), 64'd0);
    chk("old_product_held", 64'(product), 64'(prev_p));
    chk("old_neg_held", 64'(neg), 64'(prev_neg));

    cycles = 0;
    while (busy === 1'b1 && cycles < W + 4) begin
      cycles++;
      start = 1'($urandom);
      scramble_inputs();
      @(negedge clock);
    end
    start = 1'b0;

    chk("run_length", 64'(cycles), 64'(exp_len));
    chk("done", 64'(done), 64'd1);
    chk("product", 64'(product), 64'(exp_p));
    chk("neg", 64'(neg), 64'(exp_neg));
    chk("zflag", 64'(zflag), 64'(exp_p == 0));
    chk("sign", 64'(sign), exp_neg ? 64'hA : 64'hC);

    @(negedge clock);
    chk("hold_done", 64'(done), 64'd1);
    chk("hold_product", 64'(product), 64'(exp_p));
    prev_p   = exp_p;
    prev_neg = exp_neg;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_neg", 64'(neg), 64'd0);
    chk("rst_zflag", 64'(zflag), 64'd1);
    chk("rst_sign", 64'(sign), 64'hC);
    rst = 1'b0;

    run_op(1'b1, 8'h85, 8'h03);
    run_op(1'b1, 8'h00, 8'h83);
    run_op(1'b0, 8'hFF, 8'hFF);
    run_op(1'b1, 8'h7F, 8'hFF);
    run_op(1'b1, 8'h02, 8'h05);
    run_op(1'b1, 8'h80, 8'h05);

    // Abort a multiply in its second RUN cycle.
    @(negedge clock);
    start = 1'b1; signed_mode = 1'b1; multiplier = 8'h7F; multiplicand = 8'h7F;
    @(negedge clock);
    start = 1'b0;
    chk("abort_busy_before", 64'(busy), 64'd1);
    @(negedge clock);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    start = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_product", 64'(product), 64'd0);
    chk("abort_zflag", 64'(zflag), 64'd1);
    chk("abort_sign", 64'(sign), 64'hC);
    prev_p   = 0;
    prev_neg = 1'b0;
    run_op(1'b1, 8'h7F, 8'h7F);

    for (int k = 0; k < 40; k++)
      run_op(1'($urandom), W'($urandom), W'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: W, default 8, operand width in bits; SHALL be at least 4.
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: start  input  1  request to begin a multiply; sampled on clock edge.
REQ-005 Port: signed_mode  input  1  1 = sign-magnitude operands (MSB = sign, W-1 magnitude bits); 0 = unsigned W-bit operands.
REQ-006 Port: multiplier  input  W  multiplier operand.
REQ-007 Port: multiplicand  input  W  multiplicand operand.
REQ-008 Port: busy  output  1  high while the multiply is running (state RUN).
REQ-009 Port: done  output  1  high while a valid result is held (state DONE).
REQ-010 Port: product  output  2W  registered product magnitude, zero-extended.
REQ-011 Port: neg  output  1  registered result sign, 1 = negative.
REQ-012 Port: zflag  output  1  high when product == 0.
REQ-013 Port: sign  output  4  display sign code: 4'b1010 when neg = 1, else 4'b1100.

Function
REQ-014 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 start high in IDLE or DONE SHALL capture multiplier, multiplicand and signed_mode, clear the accumulator and enter RUN on the same edge.
REQ-016 start while in RUN SHALL be ignored; operand or mode changes after capture SHALL have no effect.
REQ-017 Capture: signed_mode = 1 -> magnitudes = operand[W-2:0], sign = multiplier[W-1] XOR multiplicand[W-1]; signed_mode = 0 -> magnitudes = full W bits, sign = 0.
REQ-018 Each RUN edge: if multiplier-register bit 0 = 1, accumulator += multiplicand register (2W bits, no overflow possible); multiplier register shifts right by 1; multiplicand register shifts left by 1.
REQ-019 Early termination: RUN SHALL exit to DONE on the edge where the shifted multiplier register becomes zero. RUN length = max(1, index of highest set magnitude bit + 1) cycles; a zero multiplier takes exactly 1 RUN cycle.
REQ-020 On entry to DONE, product SHALL load the final accumulator, and neg SHALL load the captured sign ANDed with (product != 0); negative zero is never reported.
REQ-021 zflag and sign SHALL be combinational from the registered product/neg; busy and done are decoded from state.
REQ-022 product, neg, done SHALL hold in DONE until the next accepted start or rst; on restart from DONE, done drops and product/neg keep their old values until the new result loads.
REQ-023 Total latency: start edge to done high = 1 + RUN length edges; maximum is W edges (signed) or W+1 edges (unsigned).

Reset
REQ-024 rst high at a clock edge SHALL force IDLE, clear all internal registers, and set product = 0, neg = 0, so busy = 0, done = 0, zflag = 1, sign = 4'b1100.
REQ-025 rst SHALL take priority over start, including rst asserted mid-RUN (the operation is aborted and no result is produced).

Verification
REQ-026 W=8, signed: multiplier 8'h85, multiplicand 8'h03, start 1 cycle -> busy for 3 cycles, then done = 1, product = 16'd15, neg = 1, sign = 4'b1010.
REQ-027 Signed: multiplier 8'h00, multiplicand 8'h83 -> 1 RUN cycle, product = 0, zflag = 1, neg = 0, sign = 4'b1100.
REQ-028 Unsigned: 8'hFF x 8'hFF -> 8 RUN cycles, product = 16'hFE01, neg = 0.
REQ-029 Signed: 8'h7F x 8'hFF -> 7 RUN cycles, product = 16'h3F01, neg = 1; start pulses during RUN are ignored; start in DONE with 8'h02 x 8'h05 -> product = 16'd10 after 2 RUN cycles.
REQ-030 rst asserted on the 2nd RUN cycle of 8'h7F x 8'h7F -> next cycle IDLE, busy = 0, done = 0, product = 0; a subsequent start completes normally.
